// File: rtl/ones_fill_gen_pkg.sv
// Shared definitions for the ones-fill generator and its popcount counterpart,
// so both ends of the path agree on the count width.
package ones_fill_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } fill_state_t;

   localparam int DEFAULT_DATA_WIDTH = 32;

   // A count of 0..data_width ones needs one more code point than data_width bits.
   function automatic int count_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/ones_fill_gen_if.sv
// Count-in / word-out handshake bundle for the ones-fill generator.
interface ones_fill_if
   import ones_fill_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   localparam int COUNT_W = count_width(DATA_WIDTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [COUNT_W-1:0]    in_count;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_sat;

   // The slave is the generator; the master supplies counts and consumes words.
   modport master (
      output in_valid, in_count, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_count, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/ones_fill_gen_fill_shifter.sv
// Datapath of the ones-fill generator: shift register, remaining-ones counter
// and shift counter, steered by load/shift strobes from the controlling FSM.
module fill_shifter
   import ones_fill_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int COUNT_W    = count_width(DATA_WIDTH),
   localparam int SHIFT_W    = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [COUNT_W-1:0]    load_count,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  sat,
   output logic                  last_shift
);

   logic [COUNT_W-1:0] remaining;
   logic [SHIFT_W-1:0] shift_cnt;
   logic               over_limit;
   logic               fill_bit;

   assign over_limit = load_count > COUNT_W'(DATA_WIDTH);
   assign fill_bit   = remaining != '0;

   // The shift that brings the counter to DATA_WIDTH is the final one.
   assign last_shift = shift_cnt == SHIFT_W'(DATA_WIDTH - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word      <= '0;
         remaining <= '0;
         sat       <= 1'b0;
         shift_cnt <= '0;
      end else if (load) begin
         word      <= '0;
         shift_cnt <= '0;
         remaining <= over_limit ? COUNT_W'(DATA_WIDTH) : load_count;
         sat       <= over_limit;
      end else if (shift) begin
         // Bits enter at the top and walk down, so the earliest ones end up lowest.
         word      <= {fill_bit, word[DATA_WIDTH-1:1]};
         shift_cnt <= shift_cnt + SHIFT_W'(1);
         if (fill_bit) begin
            remaining <= remaining - COUNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ones_fill_gen.sv
// Serial thermometer-word generator: accepts a ones count, shifts in one bit per
// clock and presents a word with min(count, DATA_WIDTH) low ones set.
module ones_fill_gen
   import ones_fill_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input logic        clk,
   input logic        rst,
   ones_fill_if.slave bus
);

   fill_state_t           state;
   fill_state_t           next_state;
   logic                  load;
   logic                  shift;
   logic                  last_shift;
   logic                  accept;
   logic [DATA_WIDTH-1:0] word;
   logic                  sat;

   assign accept = (state == IDLE) && !rst;

   fill_shifter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .shift      (shift),
      .load_count (bus.in_count),
      .word       (word),
      .sat        (sat),
      .last_shift (last_shift)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // No bypass: a finished word must be taken before IDLE can accept again.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid && accept) begin
               load       = 1'b1;
               next_state = FILL;
            end
         end
         FILL: begin
            shift = 1'b1;
            if (last_shift) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = accept;
   assign bus.out_valid = state == DONE;
   assign bus.out_data  = word;
   assign bus.out_sat   = sat;

endmodule

// File: tb/tb_ones_fill_gen.sv
// Self-checking bench for ones_fill_gen: directed corner cases with literal
// expectations, then randomized traffic checked against a count-queue model.
module tb_ones_fill_gen;
   import ones_fill_pkg::*;

   localparam int DW = 32;

   typedef struct {
      int     count;
      longint accept_edge;
   } job_t;

   logic   clk = 1'b0;
   logic   rst;
   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   job_t   pending[$];
   bit     first_seen = 1'b0;
   bit     expect_ready = 1'b0;

   always #5 clk = ~clk;

   ones_fill_if #(.DATA_WIDTH(DW)) bus ();

   ones_fill_gen #(.DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
      end
   endtask

   function automatic int clipped(input int count);
      return (count > DW) ? DW : count;
   endfunction

   function automatic logic [DW-1:0] model_word(input int count);
      logic [63:0] w;
      w = (64'd1 << clipped(count)) - 64'd1;
      return w[DW-1:0];
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge rst) begin
      pending.delete();
      first_seen   = 1'b0;
      expect_ready = 1'b0;
   end

   // Model: every accepted count must come back, in order, DW edges later.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         checkOutput("rst_in_ready", bus.in_ready, 0);
         checkOutput("rst_out_valid", bus.out_valid, 0);
         checkOutput("rst_out_data", bus.out_data, 0);
         checkOutput("rst_out_sat", bus.out_sat, 0);
      end else begin
         checkOutput("ready_valid_exclusive", bus.in_ready & bus.out_valid, 0);
         if (expect_ready) begin
            checkOutput("in_ready_after_out_hs", bus.in_ready, 1);
            expect_ready = 1'b0;
         end
         if (bus.out_valid) begin
            if (pending.size() == 0) begin
               checkOutput("unexpected_out_valid", bus.out_valid, 0);
            end else begin
               if (!first_seen) begin
                  checkOutput("latency", cyc - pending[0].accept_edge, DW);
                  first_seen = 1'b1;
               end
               checkOutput("out_data", bus.out_data, model_word(pending[0].count));
               checkOutput("out_sat", bus.out_sat, pending[0].count > DW);
               checkOutput("popcount", $countones(bus.out_data), clipped(pending[0].count));
               if (bus.out_ready) begin
                  void'(pending.pop_front());
                  first_seen   = 1'b0;
                  expect_ready = 1'b1;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            pending.push_back('{count: int'(bus.in_count), accept_edge: cyc + 1});
         end
      end
   end

   task automatic applyStimulus(input int count, input int hold, input logic [DW-1:0] exp_data, input logic exp_sat);
      int t;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_count  = 6'(count);
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      checkOutput("accept_timeout", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_count = 6'($urandom_range(0, 63));
      t = 0;
      while (!bus.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      checkOutput("valid_timeout", bus.out_valid, 1);
      for (int i = 0; i < hold; i++) begin
         checkOutput("hold_data", bus.out_data, exp_data);
         checkOutput("hold_in_ready", bus.in_ready, 0);
         checkOutput("hold_valid", bus.out_valid, 1);
         @(negedge clk);
      end
      checkOutput("dir_data", bus.out_data, exp_data);
      checkOutput("dir_sat", bus.out_sat, exp_sat);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("dir_in_ready_next", bus.in_ready, 1);
      checkOutput("dir_valid_dropped", bus.out_valid, 0);
   endtask

   initial begin
      int t;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_count  = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", bus.in_ready, 1);

      applyStimulus(0,  0,  32'h0000_0000, 1'b0);
      applyStimulus(5,  0,  32'h0000_001F, 1'b0);
      applyStimulus(31, 0,  32'h7FFF_FFFF, 1'b0);
      applyStimulus(32, 0,  32'hFFFF_FFFF, 1'b0);
      applyStimulus(40, 0,  32'hFFFF_FFFF, 1'b1);
      applyStimulus(63, 0,  32'hFFFF_FFFF, 1'b1);
      applyStimulus(7,  10, 32'h0000_007F, 1'b0);

      // Abort a count-20 job partway through FILL with an asynchronous reset.
      bus.in_valid = 1'b1;
      bus.in_count = 6'd20;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_out_data", bus.out_data, 0);
      checkOutput("abort_out_valid", bus.out_valid, 0);
      checkOutput("abort_in_ready", bus.in_ready, 0);
      checkOutput("abort_out_sat", bus.out_sat, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checkOutput("abort_no_valid", bus.out_valid, 0);
      end
      applyStimulus(3, 0, 32'h0000_0007, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_count  = 6'($urandom_range(0, 63));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("drain_empty", pending.size(), 0);
      checkOutput("drain_idle", bus.in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
